// File: rtl/mem_ctrl.sv
// mem_ctrl: splits core data/fetch accesses into byte transactions on the unified RAM.
// One data slot and one fetch slot hold requests that arrive while busy; data has priority.
// Results are raw little-endian bytes, zero-filled above the access size.

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef INST_TYPE_WIDTH
`define INST_TYPE_WIDTH 6
`endif
`ifndef INST_LB
`define INST_LB  6'd1
`define INST_LH  6'd2
`define INST_LW  6'd3
`define INST_LBU 6'd4
`define INST_LHU 6'd5
`define INST_SB  6'd6
`define INST_SH  6'd7
`define INST_SW  6'd8
`endif

module mem_ctrl (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rdy,
  input  logic                        clear,
  input  logic                        slb_load_req,
  input  logic                        slb_store_req,
  input  logic [`INST_TYPE_WIDTH-1:0] slb_type,
  input  logic [`DATA_WIDTH-1:0]      slb_vj,
  input  logic [`DATA_WIDTH-1:0]      slb_vk,
  input  logic [`DATA_WIDTH-1:0]      slb_a,
  output logic                        data_ok,
  output logic [`DATA_WIDTH-1:0]      data_ans,
  input  logic                        if_req,
  input  logic [31:0]                 if_pc,
  output logic                        if_ok,
  output logic [`DATA_WIDTH-1:0]      if_inst,
  input  logic [7:0]                  mem_din,
  output logic [7:0]                  mem_dout,
  output logic [31:0]                 mem_a,
  output logic                        mem_wr,
  input  logic                        io_buffer_full
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

  function automatic logic [2:0] acc_size(input logic [`INST_TYPE_WIDTH-1:0] t);
    case (t)
      `INST_LB, `INST_LBU, `INST_SB: acc_size = 3'd1;
      `INST_LH, `INST_LHU, `INST_SH: acc_size = 3'd2;
      default:                       acc_size = 3'd4;
    endcase
  endfunction

  state_e      state_q;
  logic [2:0]  k_q, op_size_q;
  logic        op_fetch_q, squash_q;
  logic [31:0] op_base_q, op_vk_q, rd_buf_q;
  logic        dp_valid_q, dp_store_q;
  logic [2:0]  dp_size_q;
  logic [31:0] dp_addr_q, dp_vk_q;
  logic        fp_valid_q;
  logic [31:0] fp_pc_q;

  logic        live_data;
  logic [2:0]  live_size;
  logic [31:0] live_addr;
  logic        pick_dp, pick_dl, pick_fp, pick_fl, launch;
  logic        l_store, l_fetch;
  logic [2:0]  l_size;
  logic [31:0] l_addr, l_vk;
  logic        stall, last_wr;
  logic [2:0]  k_nx, k_m1;
  logic [31:0] rd_word;

  // Idle arbitration: pending data, live data, pending fetch, live fetch.
  always_comb begin
    live_data = slb_load_req | slb_store_req;
    live_size = acc_size(slb_type);
    live_addr = slb_vj + slb_a;
    pick_dp   = dp_valid_q;
    pick_dl   = !dp_valid_q && live_data;
    pick_fp   = !dp_valid_q && !live_data && fp_valid_q;
    pick_fl   = !dp_valid_q && !live_data && !fp_valid_q && if_req;
    launch    = pick_dp | pick_dl | pick_fp | pick_fl;
    l_store   = 1'b0;
    l_fetch   = 1'b0;
    l_size    = 3'd4;
    l_addr    = if_pc;
    l_vk      = '0;
    if (pick_dp) begin
      l_store = dp_store_q;
      l_size  = dp_size_q;
      l_addr  = dp_addr_q;
      l_vk    = dp_vk_q;
    end else if (pick_dl) begin
      l_store = slb_store_req;
      l_size  = live_size;
      l_addr  = live_addr;
      l_vk    = slb_vk;
    end else begin
      l_fetch = 1'b1;
      l_addr  = pick_fp ? fp_pc_q : if_pc;
    end
  end

  // Byte stepping helpers, IO stall and the gated write strobe.
  always_comb begin
    k_nx    = k_q + 3'd1;
    k_m1    = k_q - 3'd1;
    last_wr = (k_nx == op_size_q);
    stall   = (state_q == StWrite) && (mem_a[17:16] == 2'b11) && io_buffer_full;
    mem_wr  = rdy && (state_q == StWrite) && !stall;
    // mem_din carries the byte addressed one cycle earlier, i.e. byte k-1.
    rd_word = rd_buf_q;
    rd_word[{k_m1[1:0], 3'b000} +: 8] = mem_din;
  end

  // Sequencer: launch, byte stepping, result capture, flush and pending-slot bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      k_q        <= '0;
      op_size_q  <= '0;
      op_fetch_q <= 1'b0;
      squash_q   <= 1'b0;
      op_base_q  <= '0;
      op_vk_q    <= '0;
      rd_buf_q   <= '0;
      dp_valid_q <= 1'b0;
      dp_store_q <= 1'b0;
      dp_size_q  <= '0;
      dp_addr_q  <= '0;
      dp_vk_q    <= '0;
      fp_valid_q <= 1'b0;
      fp_pc_q    <= '0;
      mem_a      <= '0;
      mem_dout   <= '0;
      data_ok    <= 1'b0;
      data_ans   <= '0;
      if_ok      <= 1'b0;
      if_inst    <= '0;
    end else if (rdy) begin
      data_ok <= 1'b0;
      if_ok   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (!clear && launch) begin
            state_q    <= l_store ? StWrite : StRead;
            k_q        <= '0;
            op_fetch_q <= l_fetch;
            op_size_q  <= l_size;
            op_base_q  <= l_addr;
            op_vk_q    <= l_vk;
            rd_buf_q   <= '0;
            mem_a      <= l_addr;
            mem_dout   <= l_vk[7:0];
            if (pick_dp) dp_valid_q <= 1'b0;
            if (pick_fp) fp_valid_q <= 1'b0;
          end
        end
        StRead: begin
          if (clear) begin
            state_q <= StIdle;
          end else if (k_q == op_size_q) begin
            state_q <= StIdle;
            if (op_fetch_q) begin
              if_inst <= rd_word;
              if_ok   <= 1'b1;
            end else begin
              data_ans <= rd_word;
              data_ok  <= 1'b1;
            end
          end else begin
            if (k_q != 3'd0) rd_buf_q <= rd_word;
            k_q   <= k_nx;
            mem_a <= op_base_q + {29'd0, k_nx};
          end
        end
        StWrite: begin
          // A store already on the bus finishes; a flush only hides its completion.
          if (clear) squash_q <= 1'b1;
          if (!stall) begin
            if (last_wr) begin
              state_q  <= StIdle;
              squash_q <= 1'b0;
              data_ok  <= !(squash_q || clear);
            end else begin
              k_q      <= k_nx;
              mem_a    <= op_base_q + {29'd0, k_nx};
              mem_dout <= op_vk_q[{k_nx[1:0], 3'b000} +: 8];
            end
          end
        end
        default: state_q <= StIdle;
      endcase
      if (clear) begin
        if (!dp_store_q) dp_valid_q <= 1'b0;
        fp_valid_q <= 1'b0;
      end else begin
        if (live_data && !(state_q == StIdle && pick_dl)) begin
          dp_valid_q <= 1'b1;
          dp_store_q <= slb_store_req;
          dp_size_q  <= live_size;
          dp_addr_q  <= live_addr;
          dp_vk_q    <= slb_vk;
        end
        if (if_req && !(state_q == StIdle && pick_fl)) begin
          fp_valid_q <= 1'b1;
          fp_pc_q    <= if_pc;
        end
      end
    end
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory controller between the core and the byte-wide unified RAM. It serves data requests from the store/load buffer (LB/LH/LW/LBU/LHU/SB/SH/SW) and instruction-fetch requests, and splits each access into sequential byte transactions. Raw little-endian data goes back with a one-cycle `ok` pulse. It also handles the IO write back-pressure and the pipeline-flush (clear) semantics.

## Interface
Parameters:
- none; widths come from the codebase macros (`DATA_WIDTH` = 32, `INST_TYPE_WIDTH`).

Ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- clear  in  1  pipeline flush
- slb_load_req  in  1  single-cycle pulse: load request
- slb_store_req  in  1  single-cycle pulse: store request
- slb_type  in  `INST_TYPE_WIDTH`  load/store type
- slb_vj  in  32  base register value
- slb_vk  in  32  store data
- slb_a  in  32  immediate offset
- data_ok  out  1  one-cycle pulse: data access complete
- data_ans  out  32  raw load bytes, zero-filled above access size
- if_req  in  1  single-cycle pulse: fetch request
- if_pc  in  32  fetch address
- if_ok  out  1  one-cycle pulse: fetch complete
- if_inst  out  32  fetched word
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  RAM write strobe
- io_buffer_full  in  1  IO write back-pressure

## Operation
- Access size from slb_type:
  - 1 byte: LB, LBU, SB
  - 2 bytes: LH, LHU, SH
  - 4 bytes: LW, SW, fetch
- Data address: slb_vj + slb_a, mod 2^32. Byte k is at base+k, mod 2^32.
- States: IDLE, READ, WRITE. Byte counter k.
- Pending slots: one data slot (type, address, vk, load/store flag) and one fetch slot.
  - A request arriving while not IDLE is latched into its slot.
  - A request while the slot is already full is a protocol violation.
- IDLE arbitration, highest priority first: pending data, live data, pending fetch, live fetch.
  - Loads and fetches go to READ; stores go to WRITE; k <= 0.
  - The chosen live request is not also latched.
- READ, byte count n:
  - For k<n: drive mem_a = base+k, mem_wr = 0.
  - For k≥1: mem_din holds byte k-1; store it into bits [8(k-1)+7 : 8(k-1)].
  - At k==n, on the clock edge: register the result, pulse data_ok or if_ok, go to IDLE.
- WRITE:
  - Drive mem_wr = 1, mem_a = base+k, mem_dout = vk[8k+7:8k]; k increments each cycle.
  - IO address (addr[17:16]==2'b11) with io_buffer_full high: mem_wr = 0 and k holds.
  - After byte n-1: pulse data_ok, go to IDLE.
- Outside READ/WRITE: mem_wr = 0.
- data_ans/if_inst keep their value between pulses.
- clear (when rdy):
  - In-flight load or fetch is aborted; IDLE next cycle; no ok pulse.
  - In-flight store runs to completion with data_ok suppressed (squash flag).
  - Pending load and pending fetch are dropped; a pending store is kept.
  - Requests presented in the clear cycle are ignored.
- rdy low: no state change; mem_wr forced 0.

## Timing
- Reset values: state IDLE, k 0, slots empty, squash 0.
- All outputs reset to 0: mem_wr, mem_a, mem_dout, data_ok, data_ans, if_ok, if_inst.
- Load of n bytes requested in cycle t (controller IDLE): READ in t+1..t+n+1; data_ok high in t+n+2.
  - LB: t+3. LW: t+6.
- Store of n bytes: writes in t+1..t+n; data_ok in t+n+1 (plus any IO stall cycles).
- Fetch: if_ok in t+6.
- The controller is IDLE in the cycle its ok pulse is high, so it can start the next access in that cycle.
- Simultaneous data and fetch requests: data wins; the fetch waits in its slot.
- Reset mid-access: the access is abandoned at once; no ok pulse; mem_wr is 0 the next cycle.

## Test plan
- LW from 0x100, RAM bytes 11 22 33 44, request at t: mem_a = 0x100..0x103 in t+1..t+4; data_ok in t+6 with data_ans = 0x44332211.
- SH with vj=0x200, a=-2, vk=0xABCD1234: mem_wr at 0x1FE=0x34, then 0x1FF=0x12; data_ok in t+3; RAM elsewhere unchanged.
- if_req and slb_load_req (LBU at 0x10, RAM byte 0x80) in the same cycle: data_ok first with data_ans = 0x00000080; if_ok follows with the fetched word; no lost request.
- SB to 0x30000 with io_buffer_full high for 3 cycles: mem_wr stays 0 for those 3 cycles, then one write; data_ok in t+5.
- Fetch in flight plus clear: no if_ok; IDLE next cycle.
- SW in flight (2 bytes written) plus clear: remaining 2 bytes are still written; no data_ok.
- A new LB issued immediately after the clear completes normally.
